// File: rtl/lu_seq_pkg.sv
// Shared types and helpers for the logical-unit sequencer.
// The state encoding is common to the sequencer and anything that observes it.
package lu_seq_pkg;

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    ACCUM  = 3'd1,
    BIAS   = 3'd2,
    WAIT   = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  // The bias word sits directly after the weights in the ROM.
  function automatic int unsigned bias_addr(input int unsigned input_size);
    return input_size;
  endfunction

endpackage

// File: rtl/lu_sequencer.sv
// Initiator-side controller for one logical_unit MAC: streams activations and weight
// addresses into the unit, adds the bias, then hands the captured result downstream.
module lu_sequencer
  import lu_seq_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int INPUT_SIZE = 8,
  parameter int LU_LATENCY = 1,
  parameter int ADDR_W     = $clog2(INPUT_SIZE + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [WORD_SIZE-1:0] lu_data_o,
  output logic                 lu_sum_en_o,
  output logic                 lu_add_bias_o,
  output logic                 lu_reset_o,
  input  logic [WORD_SIZE-1:0] lu_result_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WORD_SIZE-1:0] data_o
);

  localparam int WAIT_W = $clog2(LU_LATENCY + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(INPUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(bias_addr(INPUT_SIZE));
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LU_LATENCY);

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   count_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic                accept_s;
  logic                wait_done_s;

  // Decodes straight off the state register, so they are glitch-free; the unit is
  // held cleared for as long as the sequencer sits in reset.
  assign ready_o     = (state_r == ACCUM);
  assign lu_reset_o  = (state_r == CLEAR);
  assign accept_s    = valid_i && (state_r == ACCUM);
  assign wait_done_s = (state_r == WAIT) && (wait_cnt_r == WAIT_LAST);

  // ROM address: the weight for the activation being accepted, then the bias word.
  always_comb begin
    mem_addr_o = {ADDR_W{1'b0}};
    case (state_r)
      ACCUM:   mem_addr_o = count_r;
      BIAS:    mem_addr_o = BIAS_ADDR;
      default: mem_addr_o = {ADDR_W{1'b0}};
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CLEAR: state_next_s = ACCUM;
      ACCUM: begin
        if (accept_s && (count_r == LAST_IDX)) begin
          state_next_s = BIAS;
        end else begin
          state_next_s = ACCUM;
        end
      end
      BIAS: state_next_s = WAIT;
      WAIT: begin
        if (wait_done_s) begin
          state_next_s = OUTPUT;
        end else begin
          state_next_s = WAIT;
        end
      end
      OUTPUT: begin
        if (ready_i) begin
          state_next_s = CLEAR;
        end else begin
          state_next_s = OUTPUT;
        end
      end
      default: state_next_s = CLEAR;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Activation index and post-bias wait counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r    <= {ADDR_W{1'b0}};
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      if (state_r == CLEAR) begin
        count_r <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
        count_r <= count_r + ADDR_W'(1);
      end
      if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
    end
  end

  // Unit control is delayed one cycle so it lines up with the ROM's read data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lu_data_o     <= {WORD_SIZE{1'b0}};
      lu_sum_en_o   <= 1'b0;
      lu_add_bias_o <= 1'b0;
    end else begin
      if (accept_s) begin
        lu_data_o <= data_i;
      end
      lu_sum_en_o   <= accept_s || (state_r == BIAS);
      lu_add_bias_o <= (state_r == BIAS);
    end
  end

  // Result capture and downstream handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      data_o  <= {WORD_SIZE{1'b0}};
    end else begin
      if (wait_done_s) begin
        valid_o <= 1'b1;
        data_o  <= lu_result_i;
      end else if ((state_r == OUTPUT) && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lu_sequencer.sv
// Self-checking bench: two sequencers (LU latency 1 and 3) each driving a behavioural
// Q4.12 logical unit and a 1-cycle weight ROM, checked against a neuron-level model.
module tb_lu_sequencer;

  localparam int IS = 3;
  localparam int AW = 2;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        valid_in  [2];
  logic [15:0] data_in   [2];
  logic        ready_in  [2];
  logic        ready_out [2];
  logic        valid_out [2];
  logic        lu_sum_en [2];
  logic        lu_add_bias [2];
  logic        lu_rst    [2];
  logic [AW-1:0] mem_addr [2];
  logic [15:0] lu_data   [2];
  logic [15:0] lu_res    [2];
  logic [15:0] data_out  [2];
  logic [15:0] rom [2][4];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sat40(input logic signed [39:0] v);
    if (v > 40'sd32767) return 16'h7FFF;
    else if (v < -40'sd32768) return 16'h8000;
    else return v[15:0];
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = (g == 0) ? 1 : 3;
      logic [15:0]        mem_q;
      logic signed [31:0] prod;
      logic signed [39:0] term;
      logic signed [39:0] acc;
      logic [15:0]        sat_now;

      lu_sequencer #(.WORD_SIZE(16), .INPUT_SIZE(IS), .LU_LATENCY(L), .ADDR_W(AW)) dut (
        .clk_i(clk), .reset_i(rst),
        .valid_i(valid_in[g]), .ready_o(ready_out[g]), .data_i(data_in[g]),
        .mem_addr_o(mem_addr[g]), .lu_data_o(lu_data[g]),
        .lu_sum_en_o(lu_sum_en[g]), .lu_add_bias_o(lu_add_bias[g]), .lu_reset_o(lu_rst[g]),
        .lu_result_i(lu_res[g]),
        .valid_o(valid_out[g]), .ready_i(ready_in[g]), .data_o(data_out[g])
      );

      always_ff @(posedge clk) mem_q <= rom[g][mem_addr[g]];

      always_comb begin
        prod = $signed(lu_data[g]) * $signed(mem_q);
        if (lu_add_bias[g]) term = $signed(mem_q);
        else term = prod >>> 12;
      end

      always_ff @(posedge clk) begin
        if (lu_rst[g]) acc <= '0;
        else if (lu_sum_en[g]) acc <= acc + term;
      end

      assign sat_now = sat40(acc);

      if (L == 1) begin : g_direct
        assign lu_res[g] = sat_now;
      end else begin : g_pipe
        logic [15:0] dly [L-1];
        always_ff @(posedge clk) begin
          dly[0] <= sat_now;
          for (int k = 1; k < L - 1; k++) dly[k] <= dly[k-1];
        end
        assign lu_res[g] = dly[L-2];
      end
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic void push_exp(input int i, input logic [15:0] v);
    if (i == 0) exp0.push_back(v);
    else exp1.push_back(v);
  endfunction

  // Neuron result from first principles: truncated Q4.12 products plus bias, saturated.
  function automatic logic [15:0] ref_neuron(input int i, input logic [15:0] x0, x1, x2);
    longint s = 0;
    logic [15:0] xs [3];
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    for (int k = 0; k < IS; k++)
      s += (longint'($signed(xs[k])) * longint'($signed(rom[i][k]))) >>> 12;
    s += longint'($signed(rom[i][IS]));
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  // Monitor state
  logic        prev_valid [2];
  logic        prev_stall [2];
  logic        prev_lrst  [2];
  logic        cleared    [2];
  logic [15:0] prev_data  [2];
  int          wp [2];
  int          bp [2];
  int          last_acc [2];
  int          lat_meas [2];

  task automatic mon(input int i);
    int lat;
    logic [15:0] e;
    lat = (i == 0) ? 1 : 3;
    if (rst) begin
      chk("reset_pins", {27'd0, lu_rst[i], ready_out[i], valid_out[i], lu_sum_en[i], lu_add_bias[i]},
          32'b10000);
      cleared[i] = 1'b0; wp[i] = 0; bp[i] = 0;
      prev_valid[i] = 1'b0; prev_stall[i] = 1'b0; prev_lrst[i] = 1'b0;
    end else begin
      chk("bias_without_sum", {31'd0, lu_add_bias[i] & ~lu_sum_en[i]}, 32'd0);
      chk("ready_valid_overlap", {31'd0, ready_out[i] & valid_out[i]}, 32'd0);
      chk("sum_in_clear_or_output", {31'd0, lu_sum_en[i] & (lu_rst[i] | valid_out[i])}, 32'd0);
      chk("clear_width", {31'd0, lu_rst[i] & prev_lrst[i]}, 32'd0);
      if (lu_sum_en[i]) begin
        chk("sum_after_clear", {31'd0, cleared[i]}, 32'd1);
        if (lu_add_bias[i]) bp[i]++;
        else wp[i]++;
      end
      if (lu_rst[i]) cleared[i] = 1'b1;
      prev_lrst[i] = lu_rst[i];
      if (valid_in[i] && ready_out[i]) last_acc[i] = cyc;
      if (valid_out[i] && !prev_valid[i]) begin
        chk("spurious_valid", {31'd0, qsize(i) > 0}, 32'd1);
        lat_meas[i] = cyc - last_acc[i];
        chk("valid_latency", lat_meas[i], 3 + lat);
        chk("weight_pulses", wp[i], IS);
        chk("bias_pulses", bp[i], 1);
        wp[i] = 0; bp[i] = 0;
      end
      if (prev_stall[i])
        chk("stall_hold", {15'd0, valid_out[i], data_out[i]}, {15'd0, 1'b1, prev_data[i]});
      if (valid_out[i] && ready_in[i]) begin
        if (qsize(i) > 0) begin
          e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
          chk("result", data_out[i], e);
        end else begin
          chk("result_unexpected", 32'd0, 32'd1);
        end
      end
      prev_valid[i] = valid_out[i];
      prev_stall[i] = valid_out[i] & ~ready_in[i];
      prev_data[i]  = data_out[i];
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) mon(i);
    end
  end

  task automatic load_rom(input int i, input logic [15:0] w0, w1, w2, b);
    rom[i][0] = w0; rom[i][1] = w1; rom[i][2] = w2; rom[i][3] = b;
  endtask

  task automatic bubble(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int i, input logic [15:0] x);
    int n;
    n = 0;
    valid_in[i] = 1'b1;
    data_in[i]  = x;
    do begin @(negedge clk); n++; end while (!ready_out[i] && n < 100);
    if (!ready_out[i]) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    valid_in[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!valid_out[i] && n < 200);
    chk("valid_timeout", {31'd0, valid_out[i]}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic consume(input int i, input int hold, output logic [15:0] res);
    bubble(hold);
    ready_in[i] = 1'b1;
    res = data_out[i];
    @(posedge clk); #1;
    ready_in[i] = 1'b0;
  endtask

  task automatic run_neuron(input int i, input logic [15:0] x0, x1, x2,
                            input int gap, input int hold, output logic [15:0] res);
    push_exp(i, ref_neuron(i, x0, x1, x2));
    send(i, x0);
    bubble(gap);
    send(i, x1);
    send(i, x2);
    wait_valid(i);
    consume(i, hold, res);
  endtask

  function automatic logic [15:0] rnd_word();
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    else return 16'($urandom_range(0, 16'h3FFF) - 32'h2000);
  endfunction

  initial begin
    logic [15:0] res;
    logic [15:0] nw [3];
    logic [15:0] nx [3];
    logic [15:0] nb;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    logic [15:0] nw [3];
    logic [15:0] nx [3];
    logic [15:0] nb;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid_in[i] = 1'b0; data_in[i] = 16'h0000; ready_in[i] = 1'b0;
      last_acc[i] = 0; lat_meas[i] = 0;
      for (int a = 0; a < 4; a++) rom[i][a] = 16'h0000;
    end
    bubble(3);
    chk("reset_data_o", data_out[0], 32'h0);
    chk("reset_mem_addr", {30'd0, mem_addr[0]}, 32'h0);
    chk("reset_lu_data", lu_data[0], 32'h0);
    chk("reset_lu_reset", {31'd0, lu_rst[0]}, 32'h1);
    rst = 1'b0;
    bubble(1);

    // Case 1: basic neuron
    load_rom(0, 16'h1000, 16'h1000, 16'h1000, 16'h0800);
    run_neuron(0, 16'h1000, 16'h2000, 16'h0400, 0, 0, res);
    chk("case1_value", res, 32'h3C00);
    chk("case1_latency", lat_meas[0], 32'd4);

    // Case 2: positive and negative saturation
    run_neuron(0, 16'h7000, 16'h7000, 16'h7000, 0, 0, res);
    chk("case2_pos_sat", res, 32'h7FFF);
    load_rom(0, 16'h9000, 16'h9000, 16'h9000, 16'h0800);
    run_neuron(0, 16'h7000, 16'h7000, 16'h7000, 0, 0, res);
    chk("case2_neg_sat", res, 32'h8000);

    // Case 3: two-cycle bubble
    load_rom(0, 16'h1000, 16'h1000, 16'h1000, 16'h0800);
    run_neuron(0, 16'h1000, 16'h2000, 16'h0400, 2, 0, res);
    chk("case3_value", res, 32'h3C00);

    // Case 4: backpressure, then an independent neuron
    run_neuron(0, 16'h1000, 16'h2000, 16'h0400, 0, 4, res);
    chk("case4_stalled_value", res, 32'h3C00);
    load_rom(0, 16'h1000, 16'h1000, 16'h1000, 16'h0000);
    run_neuron(0, 16'h1000, 16'h1000, 16'h1000, 0, 0, res);
    chk("case4_second_value", res, 32'h3000);

    // Case 5: reset mid-accumulation
    load_rom(0, 16'h1000, 16'h1000, 16'h1000, 16'h0800);
    send(0, 16'h1000);
    send(0, 16'h2000);
    rst = 1'b1;
    bubble(3);
    rst = 1'b0;
    run_neuron(0, 16'h1000, 16'h2000, 16'h0400, 0, 0, res);
    chk("case5_value", res, 32'h3C00);

    // Case 6: deeper LU pipeline
    load_rom(1, 16'h1000, 16'h1000, 16'h1000, 16'h0800);
    run_neuron(1, 16'h1000, 16'h2000, 16'h0400, 0, 0, res);
    chk("case6_value", res, 32'h3C00);
    chk("case6_extra_latency", lat_meas[1] - lat_meas[0], 32'd2);

    // Randomized neurons with bubbles, backpressure and early upstream valid
    for (int j = 0; j < 3; j++) begin nw[j] = rnd_word(); nx[j] = rnd_word(); end
    nb = rnd_word();
    load_rom(0, nw[0], nw[1], nw[2], nb);
    push_exp(0, ref_neuron(0, nx[0], nx[1], nx[2]));
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (j > 0) bubble($urandom_range(0, 2));
        send(0, nx[j]);
      end
      wait_valid(0);
      if (k < 19) begin
        for (int j = 0; j < 3; j++) begin nw[j] = rnd_word(); nx[j] = rnd_word(); end
        nb = rnd_word();
        load_rom(0, nw[0], nw[1], nw[2], nb);
        push_exp(0, ref_neuron(0, nx[0], nx[1], nx[2]));
        valid_in[0] = 1'b1;
        data_in[0]  = nx[0];
      end
      consume(0, $urandom_range(0, 3), res);
    end
    bubble(3);
    chk("queue_drained", exp0.size() + exp1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
